// File: rtl/video_pkg.sv
// Shared definitions for the video burst reader.
// Default geometry (address width, burst length width, chunk limit,
// SDRAM row size) and the reader FSM state encoding.
package video_pkg;

    localparam int unsigned ADDR_WIDTH  = 23;
    localparam int unsigned LEN_WIDTH   = 9;
    localparam int unsigned MAX_CHUNK   = 8;
    localparam int unsigned ROW_WORDS   = 512;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned CHUNK_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RECEIVE = 2'd2
    } state_e;

endpackage

// File: rtl/video_burst_reader_if.sv
// Bus bundle for video_burst_reader.
// Video side: rd_request/rd_address/rd_burst_length in, rd_available/
// rd_data/busy/overrun out. SDRAM side: mem_request/mem_address/
// mem_length out, mem_grant/mem_valid/mem_data in.
// Modports: master = the reader, slave = its environment.
interface video_burst_reader_if #(
    parameter int unsigned ADDR_WIDTH = video_pkg::ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = video_pkg::LEN_WIDTH
);

    logic                   rd_request;
    logic [ADDR_WIDTH-1:0]  rd_address;
    logic [LEN_WIDTH-1:0]   rd_burst_length;
    logic                   rd_available;
    logic [31:0]            rd_data;
    logic                   busy;
    logic                   overrun;
    logic                   mem_request;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [3:0]             mem_length;
    logic                   mem_grant;
    logic                   mem_valid;
    logic [31:0]            mem_data;

    modport master (
        input  rd_request, rd_address, rd_burst_length,
        input  mem_grant, mem_valid, mem_data,
        output rd_available, rd_data, busy, overrun,
        output mem_request, mem_address, mem_length
    );

    modport slave (
        output rd_request, rd_address, rd_burst_length,
        output mem_grant, mem_valid, mem_data,
        input  rd_available, rd_data, busy, overrun,
        input  mem_request, mem_address, mem_length
    );

endinterface

// File: rtl/burst_chunker.sv
// Combinational chunk length: min(MAX_CHUNK, remaining, words left in row).
// Ports: row_offset_i - address bits inside the SDRAM row
//        remaining_i  - words still to request for the burst
//        chunk_len_c_o - legal length of the next chunk (0 only if remaining is 0)
module burst_chunker #(
    parameter int unsigned LEN_WIDTH = video_pkg::LEN_WIDTH,
    parameter int unsigned MAX_CHUNK = video_pkg::MAX_CHUNK,
    parameter int unsigned ROW_WORDS = video_pkg::ROW_WORDS
) (
    input  logic [$clog2(ROW_WORDS)-1:0] row_offset_i,
    input  logic [LEN_WIDTH-1:0]         remaining_i,
    output logic [3:0]                   chunk_len_c_o
);

    localparam int unsigned ROW_BITS  = $clog2(ROW_WORDS);
    localparam int unsigned ROW_CNT_W = ROW_BITS + 1;

    logic [ROW_CNT_W-1:0] row_left;
    logic [3:0]           cand;

    // Three-way minimum, compared in a common 32-bit domain.
    always_comb begin
        row_left = ROW_CNT_W'(ROW_WORDS) - {1'b0, row_offset_i};
        cand     = 4'(MAX_CHUNK);
        if (32'(remaining_i) < 32'(cand)) begin
            cand = 4'(remaining_i);
        end
        if (32'(row_left) < 32'(cand)) begin
            cand = 4'(row_left);
        end
        chunk_len_c_o = cand;
    end

endmodule

// File: rtl/video_burst_reader.sv
// Splits a video_controller row burst into SDRAM chunks that never exceed
// MAX_CHUNK words and never cross a ROW_WORDS boundary; forwards each
// returned word as a one-cycle rd_available strobe one cycle after mem_valid.
// Ports: clk, reset (synchronous, active-low), bus (video_burst_reader_if.master).
// Optional build macro BURST_READER_ABORT_EN: a request while busy aborts the
// current burst (owed words of the granted chunk are drained and dropped)
// and restarts with the new address/length. Without it the request is
// ignored. overrun is set in both cases.
module video_burst_reader #(
    parameter int unsigned ADDR_WIDTH = video_pkg::ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = video_pkg::LEN_WIDTH,
    parameter int unsigned MAX_CHUNK  = video_pkg::MAX_CHUNK,
    parameter int unsigned ROW_WORDS  = video_pkg::ROW_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    video_burst_reader_if.master  bus
);

    import video_pkg::*;

    localparam int unsigned ROW_BITS = $clog2(ROW_WORDS);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [3:0]             pending_q, pending_d;
    logic                   discard_q, discard_d;
    logic                   rd_available_q, rd_available_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   mem_request_q, mem_request_d;
    logic [ADDR_WIDTH-1:0]  mem_address_q, mem_address_d;
    logic [3:0]             mem_length_q, mem_length_d;
    logic                   issue_now;
    logic                   req_while_busy;
    logic [3:0]             chunk_len;
`ifdef BURST_READER_ABORT_EN
    logic [3:0]             owed;
`endif

    // Length of the chunk that would be issued from the next addr/remaining.
    burst_chunker #(
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_CHUNK (MAX_CHUNK),
        .ROW_WORDS (ROW_WORDS)
    ) u_chunker (
        .row_offset_i  (addr_d[ROW_BITS-1:0]),
        .remaining_i   (remaining_d),
        .chunk_len_c_o (chunk_len)
    );

    assign req_while_busy = bus.rd_request && (state_q != IDLE);

    // Next-state, burst bookkeeping and video-side outputs.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        pending_d      = pending_q;
        discard_d      = discard_q;
        rd_available_d = 1'b0;
        rd_data_d      = rd_data_q;
        overrun_d      = overrun_q | req_while_busy;
        issue_now      = 1'b0;
`ifdef BURST_READER_ABORT_EN
        owed           = 4'd0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.rd_request && (bus.rd_burst_length != '0)) begin
                    addr_d      = bus.rd_address;
                    remaining_d = bus.rd_burst_length;
                    state_d     = ISSUE;
                    issue_now   = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.mem_grant) begin
                    pending_d   = mem_length_q;
                    addr_d      = addr_q + ADDR_WIDTH'(mem_length_q);
                    remaining_d = remaining_q - LEN_WIDTH'(mem_length_q);
                    state_d     = RECEIVE;
                end
            end
            RECEIVE: begin
                if (bus.mem_valid) begin
                    if (!discard_q) begin
                        rd_available_d = 1'b1;
                        rd_data_d      = bus.mem_data;
                    end
                    pending_d = pending_q - 4'd1;
                    if (pending_q == 4'd1) begin
                        discard_d = 1'b0;
                        if (remaining_q != '0) begin
                            state_d   = ISSUE;
                            issue_now = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BURST_READER_ABORT_EN
        // Abort: words already owed by the SDRAM for a granted chunk must be
        // drained before a new chunk may be issued.
        if (req_while_busy) begin
            addr_d         = bus.rd_address;
            remaining_d    = bus.rd_burst_length;
            rd_available_d = 1'b0;
            if (state_q == ISSUE) begin
                owed = bus.mem_grant ? mem_length_q : 4'd0;
            end else if (state_q == RECEIVE) begin
                owed = pending_q - {3'b000, bus.mem_valid};
            end
            if (owed != 4'd0) begin
                state_d   = RECEIVE;
                pending_d = owed;
                discard_d = 1'b1;
                issue_now = 1'b0;
            end else if (bus.rd_burst_length != '0) begin
                state_d   = ISSUE;
                discard_d = 1'b0;
                issue_now = 1'b1;
            end else begin
                state_d   = IDLE;
                discard_d = 1'b0;
                issue_now = 1'b0;
            end
        end
`endif

        busy_d = (state_d != IDLE);
    end

    // SDRAM command outputs: loaded on issue, held until grant.
    always_comb begin
        mem_request_d = mem_request_q;
        mem_address_d = mem_address_q;
        mem_length_d  = mem_length_q;
        if (issue_now) begin
            mem_request_d = 1'b1;
            mem_address_d = addr_d;
            mem_length_d  = chunk_len;
        end else if (state_d != ISSUE) begin
            mem_request_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            pending_q      <= '0;
            discard_q      <= 1'b0;
            rd_available_q <= 1'b0;
            rd_data_q      <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            mem_request_q  <= 1'b0;
            mem_address_q  <= '0;
            mem_length_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            pending_q      <= pending_d;
            discard_q      <= discard_d;
            rd_available_q <= rd_available_d;
            rd_data_q      <= rd_data_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            mem_request_q  <= mem_request_d;
            mem_address_q  <= mem_address_d;
            mem_length_q   <= mem_length_d;
        end
    end

    assign bus.rd_available = rd_available_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
    assign bus.mem_request  = mem_request_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_length   = mem_length_q;

endmodule

// File: tb/tb_video_burst_reader.sv
// Self-checking bench for video_burst_reader: the bench plays the SDRAM
// controller, plans the expected chunks/data of each burst arithmetically
// and checks the returned word stream every cycle.
module tb_video_burst_reader;

    typedef struct packed {
        logic [22:0] a;
        logic [3:0]  n;
    } chunk_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    video_burst_reader_if bus ();

    video_burst_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    chunk_t      chunks[$];
    logic [31:0] exp_q[$];
    logic        live_valid = 1'b0;
    logic        exp_avail_q = 1'b0;

    function automatic logic [31:0] fdata(input logic [22:0] a);
        return {9'h15A, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Chunk list and word stream a burst must produce.
    function automatic void plan_burst(input logic [22:0] addr, input int len);
        int a;
        int r;
        a = int'(addr);
        r = len;
        chunks.delete();
        while (r > 0) begin
            int c;
            c = 8;
            if (r < c) c = r;
            if (512 - (a % 512) < c) c = 512 - (a % 512);
            chunks.push_back('{a: 23'(a), n: 4'(c)});
            for (int k = 0; k < c; k++) exp_q.push_back(fdata(23'(a + k)));
            a = (a + c) % (1 << 23);
            r = r - c;
        end
    endfunction

    // A word driven as live must come back as rd_available one cycle later.
    always @(posedge clk) exp_avail_q <= live_valid;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("rd_available", 32'(bus.rd_available), 32'(exp_avail_q));
            if (exp_avail_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data_extra: got 0x%0h expected no word at %0t", bus.rd_data, $time);
                end else begin
                    check("rd_data", bus.rd_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic start_burst(input logic [22:0] addr, input int len);
        plan_burst(addr, len);
        bus.rd_request      = 1'b1;
        bus.rd_address      = addr;
        bus.rd_burst_length = 9'(len);
        tick();
        bus.rd_request = 1'b0;
        check("busy_rise", 32'(bus.busy), 32'd1);
    endtask

    task automatic serve_chunk(input chunk_t c, input int grant_delay, input bit gap, output bit ok);
        int t;
        t = 0;
        while (!bus.mem_request && t < 40) begin
            tick();
            t++;
        end
        if (!bus.mem_request) begin
            checks++;
            errors++;
            $display("FAIL mem_request_timeout: got 0 expected 1 for chunk 0x%0h at %0t", c.a, $time);
            ok = 1'b0;
            return;
        end
        check("mem_address", 32'(bus.mem_address), 32'(c.a));
        check("mem_length", 32'(bus.mem_length), 32'(c.n));
        repeat (grant_delay) begin
            tick();
            check("held_stable", 32'({bus.mem_request, bus.mem_address, bus.mem_length}),
                  32'({1'b1, c.a, c.n}));
        end
        bus.mem_grant = 1'b1;
        tick();
        bus.mem_grant = 1'b0;
        check("req_drop", 32'(bus.mem_request), 32'd0);
        for (int k = 0; k < int'(c.n); k++) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = fdata(c.a + 23'(k));
            live_valid    = 1'b1;
            tick();
            bus.mem_valid = 1'b0;
            live_valid    = 1'b0;
            if (gap && (k % 3 == 2)) tick();
        end
        ok = 1'b1;
    endtask

    task automatic serve_burst(input int grant_delay, input bit gap);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < chunks.size() && ok; i++) serve_chunk(chunks[i], grant_delay, gap, ok);
        check("busy_fall", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("words_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset               = 1'b0;
        bus.rd_request      = 1'b0;
        bus.rd_address      = '0;
        bus.rd_burst_length = '0;
        bus.mem_grant       = 1'b0;
        bus.mem_valid       = 1'b0;
        bus.mem_data        = '0;

        // Reset with mem_valid toggling.
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'hDEADBEEF;
        tick();
        bus.mem_valid = 1'b0;
        tick();
        check("rst_rd_available", 32'(bus.rd_available), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_mem_request", 32'(bus.mem_request), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_length", 32'(bus.mem_length), 32'd0);
        reset = 1'b1;

        // Stray mem_valid while idle is dropped.
        bus.mem_valid = 1'b1;
        bus.mem_data  = 32'h12345678;
        tick();
        bus.mem_valid = 1'b0;
        tick();
        tick();

        // 88 words from 0x100, immediate grant: 11 chunks of 8.
        start_burst(23'h000100, 88);
        check("plan88_n", 32'(chunks.size()), 32'd11);
        check("plan88_last", 32'(chunks[10].a), 32'h150);
        serve_burst(0, 1'b0);

        // Row boundary split, grant delayed 5 cycles, gaps in returned data.
        start_burst(23'h0001FD, 10);
        check("plan_row_n", 32'(chunks.size()), 32'd2);
        check("plan_row_c0", 32'({chunks[0].a, chunks[0].n}), 32'({23'h1FD, 4'd3}));
        check("plan_row_c1", 32'({chunks[1].a, chunks[1].n}), 32'({23'h200, 4'd7}));
        serve_burst(5, 1'b1);

        // Second request during a burst.
        check("overrun_pre", 32'(bus.overrun), 32'd0);
`ifdef BURST_READER_ABORT_EN
        begin
            start_burst(23'h000100, 16);
            bus.mem_grant = 1'b1;
            tick();
            bus.mem_grant = 1'b0;
            for (int k = 0; k < 3; k++) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = fdata(23'h100 + 23'(k));
                live_valid    = 1'b1;
                tick();
                bus.mem_valid = 1'b0;
                live_valid    = 1'b0;
            end
            tick();
            exp_q.delete();
            bus.rd_request      = 1'b1;
            bus.rd_address      = 23'h000400;
            bus.rd_burst_length = 9'd5;
            tick();
            bus.rd_request = 1'b0;
            check("overrun_set", 32'(bus.overrun), 32'd1);
            for (int k = 0; k < 5; k++) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = 32'hBAD00000 + 32'(k);
                tick();
                bus.mem_valid = 1'b0;
            end
            plan_burst(23'h000400, 5);
            serve_burst(0, 1'b0);
        end
`else
        start_burst(23'h000100, 88);
        bus.rd_request      = 1'b1;
        bus.rd_address      = 23'h000300;
        bus.rd_burst_length = 9'd4;
        tick();
        bus.rd_request = 1'b0;
        check("overrun_set", 32'(bus.overrun), 32'd1);
        check("ignored_addr", 32'(bus.mem_address), 32'h100);
        serve_burst(2, 1'b1);
`endif
        check("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Address wrap past 2^23-1.
        start_burst(23'h7FFFFC, 8);
        check("plan_wrap_c0", 32'({chunks[0].a, chunks[0].n}), 32'({23'h7FFFFC, 4'd4}));
        check("plan_wrap_c1", 32'({chunks[1].a, chunks[1].n}), 32'({23'h000000, 4'd4}));
        serve_burst(1, 1'b0);

        // Zero-length request is a no-op.
        bus.rd_request      = 1'b1;
        bus.rd_address      = 23'h000055;
        bus.rd_burst_length = 9'd0;
        tick();
        bus.rd_request = 1'b0;
        repeat (4) begin
            check("len0_request", 32'(bus.mem_request), 32'd0);
            check("len0_busy", 32'(bus.busy), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
